// File: rtl/ov7670_cfg_pkg.sv
// Shared state encodings, table markers and helpers for the OV7670 register-write sequencer.
package ov7670_cfg_pkg;

    typedef logic [2:0] cfg_state_t;

    localparam cfg_state_t ST_IDLE      = 3'd0;
    localparam cfg_state_t ST_FETCH     = 3'd1;
    localparam cfg_state_t ST_DECODE    = 3'd2;
    localparam cfg_state_t ST_ISSUE     = 3'd3;
    localparam cfg_state_t ST_WAIT_ACK  = 3'd4;
    localparam cfg_state_t ST_WAIT_DONE = 3'd5;
    localparam cfg_state_t ST_DELAY     = 3'd6;
    localparam cfg_state_t ST_DONE      = 3'd7;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } cfg_entry_t;

    localparam logic [15:0] CFG_END   = 16'hFFFF;
    localparam logic [15:0] CFG_DELAY = 16'hFFF0;

    localparam int                WDOG_W     = 20;
    localparam logic [WDOG_W-1:0] WDOG_LIMIT = 20'hFFFFF;

    localparam int DELAY_W = 24;

    // Reload value for the delay counter: the counter runs from this value down to 0 inclusive.
    function automatic logic [DELAY_W-1:0] delay_load(input int clk_freq, input int delay_ms);
        return DELAY_W'(clk_freq / 1000 * delay_ms - 1);
    endfunction

endpackage

// File: rtl/ov7670_cfg_rom.sv
// Registered case-statement ROM holding the OV7670 bring-up register list (RGB565, QVGA).
// TEST_TABLE selects a four-entry table: COM7 reset, DELAY, CLKRC, END.
module ov7670_cfg_rom
    import ov7670_cfg_pkg::*;
#(
    parameter int IDX_W      = 8,
    parameter bit TEST_TABLE = 1'b0
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] addr_i,
    output cfg_entry_t       entry_o
);

    logic [15:0] word_d;

    // NOTE: word_d gets a default before the case so unlisted indices cannot infer a latch.
    always_comb begin
        word_d = CFG_END;
        if (TEST_TABLE) begin
            case (int'(addr_i))
                0:       word_d = 16'h1280;
                1:       word_d = CFG_DELAY;
                2:       word_d = 16'h1101;
                default: word_d = CFG_END;
            endcase
        end else begin
            case (int'(addr_i))
                0:       word_d = 16'h1280; // COM7: soft reset
                1:       word_d = CFG_DELAY;
                2:       word_d = 16'h1101; // CLKRC: prescaler /2
                3:       word_d = 16'h1214; // COM7: QVGA, RGB output
                4:       word_d = 16'h40D0; // COM15: RGB565, full range
                5:       word_d = 16'h8C00; // RGB444 off
                6:       word_d = 16'h0400; // COM1
                7:       word_d = 16'h3A04; // TSLB
                8:       word_d = 16'h3E19; // COM14: scaled PCLK /2
                9:       word_d = 16'h7211;
                10:      word_d = 16'h73F1;
                11:      word_d = 16'h0C04; // COM3: enable scaling
                12:      word_d = 16'h1716; // HSTART
                13:      word_d = 16'h1804; // HSTOP
                14:      word_d = 16'h3224; // HREF
                15:      word_d = 16'h1902; // VSTRT
                16:      word_d = 16'h1A7A; // VSTOP
                17:      word_d = 16'h030A; // VREF
                18:      word_d = 16'h13E7; // COM8: AGC/AWB/AEC on
                19:      word_d = 16'h3DC0; // COM13: gamma, UV saturation
                default: word_d = CFG_END;
            endcase
        end
    end

    // NOTE: the ROM output register is not reset; FETCH always reloads it before DECODE reads it.
    always_ff @(posedge clk) begin
        entry_o <= word_d;
    end

endmodule

// File: rtl/ov7670_cfg_sequencer.sv
// Walks the OV7670 register table and issues each write through the SCCB start/ready handshake.
// Optional CFG_WATCHDOG_EN: skips entries stuck in the handshake and flags a sticky cfg_err.
module ov7670_cfg_sequencer
    import ov7670_cfg_pkg::*;
#(
    parameter int CLK_FREQ   = 25000000,
    parameter int DELAY_MS   = 10,
    parameter int AUTO_START = 1,
    parameter int IDX_W      = 8,
    parameter bit TEST_TABLE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_start,
    input  logic             sccb_ready,
    output logic             sccb_start,
    output logic [7:0]       sccb_address,
    output logic [7:0]       sccb_data,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] entry_idx
`ifdef CFG_WATCHDOG_EN
    ,
    output logic             cfg_err
`endif
);

    localparam logic [DELAY_W-1:0] DELAY_LOAD = delay_load(CLK_FREQ, DELAY_MS);
    localparam logic [IDX_W-1:0]   IDX_MAX    = '1;

    cfg_state_t          state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DELAY_W-1:0]  cnt_q, cnt_d;
    logic                start_q, start_d;
    logic [7:0]          addr_q, addr_d;
    logic [7:0]          data_q, data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                advance, finish, restart;
    cfg_entry_t          rom_entry;
    logic [15:0]         rom_word;

`ifdef CFG_WATCHDOG_EN
    logic [WDOG_W-1:0]   wdog_q, wdog_d;
    logic                err_q, err_d;
    logic                in_wait;
`endif

    ov7670_cfg_rom #(
        .IDX_W      (IDX_W),
        .TEST_TABLE (TEST_TABLE)
    ) u_rom (
        .clk     (clk),
        .addr_i  (idx_q),
        .entry_o (rom_entry)
    );

    assign rom_word = rom_entry;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        start_d = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        busy_d  = busy_q;
        done_d  = done_q;
        advance = 1'b0;
        finish  = 1'b0;
        restart = 1'b0;
`ifdef CFG_WATCHDOG_EN
        err_d   = err_q;
        wdog_d  = '0;
        in_wait = (state_q == ST_WAIT_ACK) || (state_q == ST_WAIT_DONE);
`endif

        case (state_q)
            ST_IDLE:      if (cfg_start || (AUTO_START != 0)) restart = 1'b1;
            ST_FETCH:     state_d = ST_DECODE;
            ST_DECODE: begin
                if (rom_word == CFG_END) begin
                    finish = 1'b1;
                end else if (rom_word == CFG_DELAY) begin
                    cnt_d   = DELAY_LOAD;
                    state_d = ST_DELAY;
                end else if (rom_entry.addr == 8'hFF) begin
                    advance = 1'b1;
                end else begin
                    addr_d  = rom_entry.addr;
                    data_d  = rom_entry.data;
                    state_d = ST_ISSUE;
                end
            end
            // start is asserted from a registered decision, so ready never reaches it combinationally
            ST_ISSUE: begin
                if (sccb_ready) begin
                    start_d = 1'b1;
                    state_d = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK:  if (!sccb_ready) state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: if (sccb_ready) advance = 1'b1;
            ST_DELAY: begin
                if (cnt_q == '0) advance = 1'b1;
                else             cnt_d   = cnt_q - DELAY_W'(1);
            end
            ST_DONE:      if (cfg_start) restart = 1'b1;
            default:      state_d = ST_IDLE;
        endcase

`ifdef CFG_WATCHDOG_EN
        if (in_wait && (wdog_q == WDOG_LIMIT)) begin
            advance = 1'b1;
            err_d   = 1'b1;
        end
`endif

        // The last index is processed but never wraps back to entry 0
        if (advance) begin
            if (idx_q == IDX_MAX) begin
                finish = 1'b1;
            end else begin
                idx_d   = idx_q + IDX_W'(1);
                state_d = ST_FETCH;
            end
        end

        if (finish) begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
        end

        if (restart) begin
            state_d = ST_FETCH;
            idx_d   = '0;
            busy_d  = 1'b1;
            done_d  = 1'b0;
`ifdef CFG_WATCHDOG_EN
            err_d   = 1'b0;
`endif
        end

`ifdef CFG_WATCHDOG_EN
        if (in_wait && (state_d == state_q)) wdog_d = wdog_q + WDOG_W'(1);
`endif
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            start_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef CFG_WATCHDOG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            err_q  <= err_d;
        end
    end

    assign cfg_err = err_q;
`endif

    assign sccb_start   = start_q;
    assign sccb_address = addr_q;
    assign sccb_data    = data_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign entry_idx    = idx_q;

endmodule

// File: tb/tb_ov7670_cfg_sequencer.sv
// Directed bench for ov7670_cfg_sequencer using the four-entry test table and a 50-cycle SCCB ready stub.
module tb_ov7670_cfg_sequencer;

    localparam int IDX_W   = 8;
    localparam int TIMEOUT = 2000;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_start;
    logic             sccb_ready;
    logic             sccb_start;
    logic [7:0]       sccb_address;
    logic [7:0]       sccb_data;
    logic             busy;
    logic             done;
    logic [IDX_W-1:0] entry_idx;
`ifdef CFG_WATCHDOG_EN
    logic             cfg_err;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ov7670_cfg_sequencer #(
        .CLK_FREQ   (1000),
        .DELAY_MS   (10),
        .AUTO_START (1),
        .IDX_W      (IDX_W),
        .TEST_TABLE (1'b1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_start    (cfg_start),
        .sccb_ready   (sccb_ready),
        .sccb_start   (sccb_start),
        .sccb_address (sccb_address),
        .sccb_data    (sccb_data),
        .busy         (busy),
        .done         (done),
        .entry_idx    (entry_idx)
`ifdef CFG_WATCHDOG_EN
        ,
        .cfg_err      (cfg_err)
`endif
    );

    // SCCB stub: ready drops for 50 cycles after each start; hold_low forces it low externally.
    logic stub_ready = 1'b1;
    int   stub_cnt   = 0;
    logic hold_low;
    assign sccb_ready = stub_ready && !hold_low;

    always @(posedge clk) begin
        if (sccb_start) begin
            stub_ready <= 1'b0;
            stub_cnt   <= 50;
        end else if (stub_cnt > 0) begin
            stub_cnt <= stub_cnt - 1;
            if (stub_cnt == 1) stub_ready <= 1'b1;
        end
    end

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    // Monitor: records every write, pulse width, ready-rise timing and address/data stability.
    int         n_wr = 0;
    logic [7:0] wr_addr [16];
    logic [7:0] wr_data [16];
    int         start_cyc [16];
    int         rise_before [16];
    int         last_rise = 0;
    int         wide = 0;
    int         unstable = 0;
    logic       prev_start = 1'b0;
    logic       prev_ready = 1'b0;
    logic       in_xfer = 1'b0;
    logic       saw_low = 1'b0;
    logic [7:0] xa, xd;

    always @(negedge clk) begin
        prev_start <= sccb_start;
        prev_ready <= sccb_ready;
        if (sccb_ready && !prev_ready) last_rise <= cycle;
        if (sccb_start && prev_start) wide <= wide + 1;
        if (sccb_start) begin
            if (n_wr < 16) begin
                wr_addr[n_wr]     <= sccb_address;
                wr_data[n_wr]     <= sccb_data;
                start_cyc[n_wr]   <= cycle;
                rise_before[n_wr] <= last_rise;
            end
            n_wr <= n_wr + 1;
        end
        if (rst) begin
            in_xfer <= 1'b0;
        end else if (sccb_start) begin
            in_xfer <= 1'b1;
            saw_low <= 1'b0;
            xa      <= sccb_address;
            xd      <= sccb_data;
        end else if (in_xfer) begin
            if (sccb_address !== xa || sccb_data !== xd) unstable <= unstable + 1;
            if (!sccb_ready)  saw_low <= 1'b1;
            else if (saw_low) in_xfer <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_start"}, sccb_start,   0);
        check({tag, "_addr"},  sccb_address, 0);
        check({tag, "_data"},  sccb_data,    0);
        check({tag, "_busy"},  busy,         0);
        check({tag, "_done"},  done,         0);
        check({tag, "_idx"},   entry_idx,    0);
    endtask

    initial begin
        rst       = 1'b1;
        cfg_start = 1'b0;
        hold_low  = 1'b1;
        repeat (3) tick();
        check_reset_outputs("reset");
`ifdef CFG_WATCHDOG_EN
        check("reset_cfg_err", cfg_err, 0);
`endif

        // Auto-start with ready held low for 200 cycles: the sequencer must park in ISSUE.
        rst = 1'b0;
        repeat (200) tick();
        check("hold_no_write", n_wr,         0);
        check("hold_start",    sccb_start,   0);
        check("hold_busy",     busy,         1);
        check("hold_idx",      entry_idx,    0);
        check("hold_addr",     sccb_address, 8'h12);
        check("hold_data",     sccb_data,    8'h80);
        hold_low = 1'b0;
        tick();
        check("first_start_hi", sccb_start, 1);
        tick();
        check("first_start_lo", sccb_start, 0);

        for (int i = 0; i < TIMEOUT && !done; i++) tick();
        check("run1_done",   done,      1);
        check("run1_busy",   busy,      0);
        check("run1_writes", n_wr,      2);
        check("run1_idx",    entry_idx, 3);
        check("run1_a0",     wr_addr[0], 8'h12);
        check("run1_d0",     wr_data[0], 8'h80);
        check("run1_a1",     wr_addr[1], 8'h11);
        check("run1_d1",     wr_data[1], 8'h01);
        // ready rise -> FETCH, DECODE, 10 DELAY cycles, FETCH, DECODE, ISSUE, start visible: 16 cycles
        check("run1_delay_gap", start_cyc[1] - rise_before[1], 16);

        // Restart from DONE.
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        check("restart_idx",  entry_idx, 0);
        check("restart_done", done,      0);
        check("restart_busy", busy,      1);

        // cfg_start during WAIT_DONE of the first write is ignored.
        for (int i = 0; i < TIMEOUT && !(n_wr == 3 && !sccb_ready); i++) tick();
        check("run2_first_write", n_wr, 3);
        tick();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        repeat (3) tick();
        check("busy_start_writes", n_wr,      3);
        check("busy_start_idx",    entry_idx, 0);
        check("busy_start_busy",   busy,      1);
        for (int i = 0; i < TIMEOUT && !done; i++) tick();
        check("run2_done",   done, 1);
        check("run2_writes", n_wr, 4);
        check("run2_a2",     wr_addr[2], 8'h12);
        check("run2_d2",     wr_data[2], 8'h80);
        check("run2_a3",     wr_addr[3], 8'h11);
        check("run2_d3",     wr_data[3], 8'h01);

        // Reset during WAIT_DONE of the first write of a third run.
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int i = 0; i < TIMEOUT && !(n_wr == 5 && !sccb_ready); i++) tick();
        check("run3_first_write", n_wr, 5);
        tick();
        rst = 1'b1;
        #1;
        check_reset_outputs("midreset");
        repeat (3) tick();
        rst = 1'b0;
        check("midreset_no_write", n_wr, 5);
        for (int i = 0; i < TIMEOUT && n_wr < 6; i++) tick();
        check("reissue_writes", n_wr,       6);
        check("reissue_a",      wr_addr[5], 8'h12);
        check("reissue_d",      wr_data[5], 8'h80);
        for (int i = 0; i < TIMEOUT && !done; i++) tick();
        check("run3_done",   done,       1);
        check("run3_busy",   busy,       0);
        check("run3_writes", n_wr,       7);
        check("run3_a6",     wr_addr[6], 8'h11);
        check("run3_d6",     wr_data[6], 8'h01);
        check("start_width", wide,       0);
        check("addr_stable", unstable,   0);
`ifdef CFG_WATCHDOG_EN
        check("final_cfg_err", cfg_err, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ov7670_cfg_sequencer.md
Name: ov7670_cfg_sequencer

Overview:
- Walks a fixed table of OV7670 register writes at power-up or on request and issues each one through the SCCB_interface start/ready handshake.
- Sits between top-level camera bring-up logic and SCCB_interface. It is the only driver of the interface's start, address and data inputs.
- Supports inline delay entries, required after the COM7 soft reset.
- Reports busy/done so the capture path is held off until the sensor is configured.

Parameters:
- CLK_FREQ, 25000000, system clock in Hz; used to size the delay counter.
- DELAY_MS, 10, length of a table delay entry in milliseconds.
- AUTO_START, 1, when 1 the sequence starts on the first cycle after reset release.
- IDX_W, 8, table index width; the table holds at most 2**IDX_W entries.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-high.
- cfg_start  input  1  one-cycle pulse; (re)starts the sequence from index 0 when in IDLE or DONE.
- sccb_ready  input  1  SCCB_interface ready; 1 = idle and able to accept a write.
- sccb_start  output  1  one-cycle write request to SCCB_interface.
- sccb_address  output  8  register address, held stable from sccb_start until ready returns high.
- sccb_data  output  8  register data, held stable with sccb_address.
- busy  output  1  sequence in progress.
- done  output  1  sequence finished; level, stays high until the next start.
- entry_idx  output  IDX_W  index of the current table entry (debug).

Behaviour:
- Reset values: sccb_start=0, sccb_address=0, sccb_data=0, busy=0, done=0, entry_idx=0, delay counter=0, state=IDLE.
- Table entries are 16 bits, {addr[15:8], data[7:0]}, read from ov7670_cfg_rom with 1-cycle registered latency.
- Special entries:
  - 16'hFFFF = END.
  - 16'hFFF0 = DELAY.
  - Register 0xFF is never written.
- States: IDLE, FETCH, DECODE, ISSUE, WAIT_ACK, WAIT_DONE, DELAY, DONE.
- IDLE -> FETCH on cfg_start, or on the first cycle after reset if AUTO_START=1. Entering FETCH clears entry_idx to 0, sets busy=1 and done=0.
- FETCH: presents entry_idx to the ROM. Next cycle -> DECODE.
- DECODE:
  - END -> DONE.
  - DELAY -> DELAY, loading the counter with CLK_FREQ/1000*DELAY_MS-1.
  - Otherwise latch sccb_address/sccb_data -> ISSUE.
- ISSUE: wait until sccb_ready=1, then drive sccb_start=1 for exactly one cycle -> WAIT_ACK.
- WAIT_ACK: wait for sccb_ready=0 (write accepted) -> WAIT_DONE.
- WAIT_DONE: wait for sccb_ready=1. Then entry_idx+1 -> FETCH.
- DELAY: decrement each cycle; at 0, entry_idx+1 -> FETCH.
- DONE: busy=0, done=1. cfg_start -> FETCH (full resequence).
- Wrap-around: if entry_idx equals 2**IDX_W-1 and that entry is not END, it is still processed and then the sequencer enters DONE. The index never wraps to 0.
- cfg_start while busy: ignored.
- Simultaneous cfg_start and reset: reset wins.
- Reset mid-transfer: everything returns to reset values immediately. SCCB_interface finishes its frame on its own; the sequencer then restarts per AUTO_START and waits in ISSUE for ready.
- The delay counter is 24 bits and must cover 25 MHz x 10 ms = 250000 cycles.
- No combinational path from sccb_ready to sccb_start; all outputs are registered.

Optional Feature:
- Macro CFG_WATCHDOG_EN.
- Defined:
  - A 20-bit watchdog counts cycles spent in WAIT_ACK/WAIT_DONE and clears on each state change.
  - At WDOG_LIMIT (package constant, 2**20-1) the sequencer skips the entry, sets the sticky output cfg_err=1, and continues with the next entry.
  - cfg_err clears on reset or on a new start.
- Undefined: no watchdog and no cfg_err port; the sequencer waits indefinitely.

Decomposition:
- Package ov7670_cfg_pkg holds:
  - state enum;
  - CFG_END=16'hFFFF and CFG_DELAY=16'hFFF0;
  - WDOG_LIMIT;
  - entry typedef {addr, data}.
- Sub-module ov7670_cfg_rom: registered case-statement ROM, IDX_W in, 16 bits out. Holds the camera register list (COM7=0x80 reset, DELAY, then the RGB565/QVGA settings, END).

Test Plan:
- Use CLK_FREQ=1000 and DELAY_MS=10 (10-cycle delay) with a ready-model SCCB stub: ready low for 50 cycles after each start.
- Test ROM {0x12,0x80}, DELAY, {0x11,0x01}, END:
  - AUTO_START=1 after rst -> exactly two sccb_start pulses, carrying address/data 0x12/0x80 then 0x11/0x01.
  - At least 10 cycles between ready rising after the first write and the second start.
  - Then done=1, busy=0.
- Stub holds sccb_ready=0 for 200 cycles after reset -> sccb_start stays 0 until ready=1, then pulses once, width 1 cycle.
- In DONE, pulse cfg_start -> entry_idx returns to 0, done drops the next cycle, and the same two writes repeat.
- While busy in WAIT_DONE, pulse cfg_start -> no effect; write count unchanged.
- Assert rst for 3 cycles during WAIT_DONE of the first write:
  - all outputs return to 0 immediately (asynchronously);
  - after release, the sequence restarts at index 0 and the first write is reissued.
- With CFG_WATCHDOG_EN and the stub never raising ready after the first start:
  - after WDOG_LIMIT cycles, cfg_err=1;
  - the second write is attempted;
  - done=1 eventually (stub released).
